// File: rtl/key_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
//   state_e     : debounce FSM states
//   frame_res_e : classification of one complete scan frame
//   count_low   : number of active-low row bits in one column sample
//   low_row_idx : index of the lowest-numbered low row bit
//   key_code    : row/column to key code 1..16
package key_scan_pkg;

  localparam int unsigned N_ROWS   = 4;
  localparam int unsigned N_COLS   = 4;
  localparam logic [4:0]  KEY_NONE = 5'd0;

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_e;
  typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_res_e;

  function automatic logic [2:0] count_low(input logic [N_ROWS-1:0] rows);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < N_ROWS; i++) begin
      n = n + 3'(~rows[i]);
    end
    return n;
  endfunction

  function automatic logic [1:0] low_row_idx(input logic [N_ROWS-1:0] rows);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_ROWS; i++) begin
      if (!rows[i] && !found) begin
        idx   = 2'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Code = row*4 + col + 1, so {row,col} + 1.
  function automatic logic [4:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return 5'({row, col}) + 5'd1;
  endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// Frame-level debounce for the keypad scanner.
//   i_clk, i_rstn  : clock, asynchronous active-low reset
//   i_frame_end    : one-cycle strobe when a scan frame completes
//   i_frame_res    : frame classification (frame_res_e encoding)
//   i_frame_code   : key code when the frame is FR_SINGLE
//   o_key_valid    : one-cycle pulse per accepted press
//   o_key_value    : last accepted key code (0 until the first press)
module key_debounce_fsm
  import key_scan_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_frame_end,
  input  logic [1:0] i_frame_res,
  input  logic [4:0] i_frame_code,
  output logic       o_key_valid,
  output logic [4:0] o_key_value
);

  localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] DF_C = CW'(DEBOUNCE_FRAMES);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0]    cand_q, cand_d;
  logic [4:0]    value_q, value_d;
  logic          valid_q, valid_d;
  logic          accept;
  logic          is_none, is_single;

  assign is_none   = (i_frame_res == FR_NONE);
  assign is_single = (i_frame_res == FR_SINGLE);
  assign cnt_inc   = cnt_q + CW'(1);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cand_q  <= KEY_NONE;
      value_q <= KEY_NONE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (i_frame_end) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_single) begin
            cand_d = i_frame_code;
            if (DEBOUNCE_FRAMES == 1) begin
              accept  = 1'b1;
              state_d = S_HELD;
              cnt_d   = '0;
            end else begin
              cnt_d   = CW'(1);
              state_d = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (is_single && (i_frame_code == cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DF_C) begin
              accept  = 1'b1;
              state_d = S_HELD;
              cnt_d   = '0;
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_HELD: begin
          // Any pressed frame (including a different key) just keeps us here.
          if (is_none) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = S_RELEASE;
              cnt_d   = CW'(1);
            end
          end
        end
        S_RELEASE: begin
          if (is_none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DF_C) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end else begin
            state_d = S_HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    valid_d = accept;
    value_d = accept ? cand_d : value_q;
  end

  assign o_key_valid = valid_q;
  assign o_key_value = value_q;

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 active-low keypad scanner with frame-level debounce.
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_row         : keypad rows, active-low, asynchronous to i_clk
//   o_col         : column drive, active-low one-hot
//   o_key_valid   : one-cycle pulse per accepted press
//   o_key_value   : last accepted key code 1..16 (0 until first press)
module key_matrix_scan
  import key_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [N_ROWS-1:0]   i_row,
  output logic [N_COLS-1:0]   o_col,
  output logic                o_key_valid,
  output logic [4:0]          o_key_value
);

  localparam int unsigned DW = $clog2(SCAN_DIV);

  logic [N_ROWS-1:0] sync1_q, sync2_q;
  logic [DW-1:0]     div_q, div_d;
  logic [1:0]        col_q, col_d;
  // Hits so far in the frame: 0, 1, or 2 meaning "two or more".
  logic [1:0]        acc_hits_q, acc_hits_d;
  logic [4:0]        acc_code_q, acc_code_d;

  logic              tick;
  logic [1:0]        base_hits;
  logic [4:0]        base_code;
  logic [2:0]        n_low;
  logic [2:0]        hits_sum;
  logic [1:0]        hits_sat;
  logic [4:0]        new_code;
  logic              frame_end;
  frame_res_e        frame_res;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      div_q      <= '0;
      col_q      <= '0;
      acc_hits_q <= '0;
      acc_code_q <= KEY_NONE;
    end else begin
      sync1_q    <= i_row;
      sync2_q    <= sync1_q;
      div_q      <= div_d;
      col_q      <= col_d;
      acc_hits_q <= acc_hits_d;
      acc_code_q <= acc_code_d;
    end
  end

  assign tick = (div_q == DW'(SCAN_DIV - 1));

  always_comb begin
    div_d = tick ? '0 : div_q + DW'(1);
    col_d = tick ? col_q + 2'd1 : col_q;

    // Column 0 starts a fresh frame, so ignore whatever the last frame left.
    base_hits = (col_q == 2'd0) ? 2'd0 : acc_hits_q;
    base_code = (col_q == 2'd0) ? KEY_NONE : acc_code_q;

    n_low    = count_low(sync2_q);
    hits_sum = {1'b0, base_hits} + n_low;
    hits_sat = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    new_code = ((base_hits == 2'd0) && (n_low == 3'd1))
               ? key_code(low_row_idx(sync2_q), col_q) : base_code;

    acc_hits_d = tick ? hits_sat : acc_hits_q;
    acc_code_d = tick ? new_code : acc_code_q;

    frame_end = tick && (col_q == 2'd3);
    unique case (hits_sat)
      2'd0:    frame_res = FR_NONE;
      2'd1:    frame_res = FR_SINGLE;
      default: frame_res = FR_MULTI;
    endcase
  end

  assign o_col = ~(N_COLS'(1) << col_q);

  key_debounce_fsm #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_frame_end (frame_end),
    .i_frame_res (frame_res),
    .i_frame_code(new_code),
    .o_key_valid (o_key_valid),
    .o_key_value (o_key_value)
  );

endmodule

// File: tb/tb_key_matrix_scan.sv
module tb_key_matrix_scan;

  localparam int unsigned SD = 8;
  localparam int unsigned DF = 3;
  localparam int unsigned FR = 4 * SD;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] i_row;
  logic [3:0] o_col;
  logic       o_key_valid;
  logic [4:0] o_key_value;
  logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c pressed

  int unsigned cyc;
  int vectors = 0;
  int miscompares = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    int unsigned val;
    int unsigned cyc;
  } exp_t;
  exp_t exp_q[$];

  key_matrix_scan #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_FRAMES(DF)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_row      (i_row),
    .o_col      (o_col),
    .o_key_valid(o_key_valid),
    .o_key_value(o_key_value)
  );

  always #5 clk = ~clk;

  // Ideal keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    i_row = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !o_col[c]) i_row[r] = 1'b0;
  end

  always @(posedge clk or negedge rstn)
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input int unsigned val, input int unsigned at);
    exp_t e;
    e.val = val;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard consumer: every pulse must match the next expected entry.
  always @(negedge clk) begin
    if (rstn === 1'b1 && o_key_valid === 1'b1) begin
      check("pulse_width", {31'b0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_pulse: observed value %0d at cycle %0d expected no pulse", o_key_value, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_value", {27'b0, o_key_value}, e.val);
        check("pulse_cycle", cyc, e.cyc);
      end
    end
    prev_valid = o_key_valid;
  end

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_col", {28'b0, o_col}, 32'hE);
    check("rst_valid", {31'b0, o_key_valid}, 32'd0);
    check("rst_value", {27'b0, o_key_value}, 32'd0);
    cycles(3);
    rstn = 1'b1;
  endtask

  initial begin
    logic [3:0] ecol;

    // 1: idle scanning, column rotation
    keys = '0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycles(SD);
      ecol = ~(4'b0001 << ((i + 1) % 4));
      check("col_seq", {28'b0, o_col}, {28'b0, ecol});
    end
    cycles(2 * FR);
    check("t1_value", {27'b0, o_key_value}, 32'd0);
    check("t1_sb_empty", exp_q.size(), 32'd0);

    // 2: clean press row1/col2 -> code 7
    do_reset();
    keys[1*4+2] = 1'b1;
    expect_pulse(7, 3 * FR);
    cycles(200);
    keys = '0;
    cycles(5 * FR);
    check("t2_hold_value", {27'b0, o_key_value}, 32'd7);
    check("t2_sb_empty", exp_q.size(), 32'd0);

    // 3: bounce on row0/col0, then steady
    do_reset();
    expect_pulse(1, 8 * FR);
    for (int f = 0; f < 9; f++) begin
      keys[0] = (f == 1) || (f == 3) || (f >= 5);
      cycles(FR);
    end
    keys = '0;
    check("t3_sb_empty", exp_q.size(), 32'd0);
    check("t3_value", {27'b0, o_key_value}, 32'd1);

    // 4: ghosting (keys 1 and 16), then release key 16
    do_reset();
    keys[0]  = 1'b1;
    keys[15] = 1'b1;
    cycles(6 * FR);
    check("t4_no_multi", {27'b0, o_key_value}, 32'd0);
    keys[15] = 1'b0;
    expect_pulse(1, 9 * FR);
    cycles(4 * FR);
    keys = '0;
    check("t4_sb_empty", exp_q.size(), 32'd0);
    check("t4_value", {27'b0, o_key_value}, 32'd1);

    // 5: long hold of key 16, one-frame glitch, full release, re-press
    do_reset();
    keys[15] = 1'b1;
    expect_pulse(16, 3 * FR);
    cycles(20 * FR);
    keys[15] = 1'b0;
    cycles(FR);
    keys[15] = 1'b1;
    cycles(3 * FR);
    check("t5_no_repeat", exp_q.size(), 32'd0);
    keys[15] = 1'b0;
    cycles(3 * FR);
    keys[15] = 1'b1;
    expect_pulse(16, 30 * FR);
    cycles(4 * FR);
    keys = '0;
    check("t5_sb_empty", exp_q.size(), 32'd0);
    check("t5_value", {27'b0, o_key_value}, 32'd16);

    // 6: reset mid-debounce with key held through reset exit
    do_reset();
    keys[1] = 1'b1;
    expect_pulse(2, 3 * FR);
    cycles(3 * FR);
    keys = '0;
    cycles(3 * FR);
    keys[5] = 1'b1;
    cycles(FR + 8);
    check("t6_pre_value", {27'b0, o_key_value}, 32'd2);
    rstn = 1'b0;
    #1;
    check("t6_rst_col", {28'b0, o_col}, 32'hE);
    check("t6_rst_valid", {31'b0, o_key_valid}, 32'd0);
    check("t6_rst_value", {27'b0, o_key_value}, 32'd0);
    cycles(5);
    check("t6_rst_hold_value", {27'b0, o_key_value}, 32'd0);
    rstn = 1'b1;
    expect_pulse(6, 3 * FR);
    cycles(4 * FR);
    keys = '0;
    check("t6_sb_empty", exp_q.size(), 32'd0);
    check("t6_value", {27'b0, o_key_value}, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
